// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcodes, FSM states, flag indices and opcode classification for the ALU sequencer
package alu_ctrl_pkg;

    localparam int DATA_W = 8;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_SUB   = 5'b00011;
    localparam logic [4:0] OP_OR    = 5'b00100;
    localparam logic [4:0] OP_XOR   = 5'b00101;
    localparam logic [4:0] OP_MOV   = 5'b00110;
    localparam logic [4:0] OP_ADC   = 5'b00111;
    localparam logic [4:0] OP_NOT   = 5'b01000;
    localparam logic [4:0] OP_SAR   = 5'b01001;
    localparam logic [4:0] OP_SLR   = 5'b01010;
    localparam logic [4:0] OP_SAL   = 5'b01011;
    localparam logic [4:0] OP_SLL   = 5'b01100;
    localparam logic [4:0] OP_ROL   = 5'b01101;
    localparam logic [4:0] OP_ROR   = 5'b01110;
    localparam logic [4:0] OP_LDI   = 5'b10000;
    localparam logic [4:0] OP_SHOWR = 5'b11111;

    localparam int FLAG_CF = 3;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_SF = 1;
    localparam int FLAG_OF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic writes_reg;
        logic writes_flags;
        logic uses_alu;
        logic illegal;
    } op_class_t;

    // Anything not explicitly listed (including the unused 01111) is treated as unsupported.
    function automatic op_class_t classify_op(input logic [4:0] op);
        op_class_t c;
        c = '0;
        case (op)
            OP_NOP, OP_SHOWR: c.illegal = 1'b0;
            OP_ADD, OP_AND, OP_SUB, OP_OR, OP_XOR, OP_ADC,
            OP_SAR, OP_SLR, OP_SAL, OP_SLL, OP_ROL, OP_ROR: begin
                c.writes_reg   = 1'b1;
                c.writes_flags = 1'b1;
                c.uses_alu     = 1'b1;
            end
            OP_MOV, OP_NOT: begin
                c.writes_reg = 1'b1;
                c.uses_alu   = 1'b1;
            end
            OP_LDI: c.writes_reg = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 8x8 register file, two asynchronous read ports, one synchronous write port
module alu_regfile
    import alu_ctrl_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [2:0]        rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    // Register storage: cleared on reset, one write per cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - single-issue ALU sequencer; optional retired counter under INSTR_COUNT_EN
module alu_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int NREGS   = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [4:0]  instr_op,
    input  logic [2:0]  instr_dst,
    input  logic [2:0]  instr_src,
    input  logic [2:0]  instr_im,
    input  logic [7:0]  instr_data,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    output logic [2:0]  alu_im,
    output logic [4:0]  alu_op,
    input  logic [7:0]  alu_res,
    input  logic        alu_cf,
    input  logic        alu_zf,
    input  logic        alu_sf,
    input  logic        alu_of,
    output logic [3:0]  flags,
    output logic        done,
    output logic        illegal,
`ifdef INSTR_COUNT_EN
    output logic [15:0] retired_count,
`endif
    output logic        show_valid,
    output logic [7:0]  show_data
);

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

    state_t     state;
    state_t     next_state;
    logic [4:0] op_q;
    logic [2:0] dst_q;
    logic [2:0] src_q;
    logic [2:0] im_q;
    logic [7:0] data_q;
    logic [3:0] lat_cnt;
    logic [7:0] rd_a;
    logic [7:0] rd_b;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       accept;
    op_class_t  cls;

    assign cls     = classify_op(op_q);
    assign accept  = (state == ST_IDLE) && instr_ready && instr_valid;
    assign wr_en   = (state == ST_WB) && cls.writes_reg;
    assign wr_data = (op_q == OP_LDI) ? data_q : alu_res;

    alu_regfile #(
        .NREGS(NREGS)
    ) u_regfile (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_addr_a (dst_q),
        .rd_data_a (rd_a),
        .rd_addr_b (src_q),
        .rd_data_b (rd_b),
        .wr_en     (wr_en),
        .wr_addr   (dst_q),
        .wr_data   (wr_data)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: ALU ops wait out the latency in EXEC, everything else goes straight to WB.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = ST_READ;
            ST_READ: next_state = cls.uses_alu ? ST_EXEC : ST_WB;
            ST_EXEC: if (lat_cnt == 4'd0) next_state = ST_WB;
            ST_WB:   next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath: instruction latch, ALU drive, latency counter, flags and retire pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_ready <= 1'b0;
            op_q        <= OP_NOP;
            dst_q       <= '0;
            src_q       <= '0;
            im_q        <= '0;
            data_q      <= '0;
            lat_cnt     <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_im      <= '0;
            alu_op      <= OP_NOP;
            flags       <= '0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            show_valid  <= 1'b0;
            show_data   <= '0;
        end else begin
            instr_ready <= (next_state == ST_IDLE);
            done        <= 1'b0;
            illegal     <= 1'b0;
            show_valid  <= 1'b0;
            if (accept) begin
                op_q   <= instr_op;
                dst_q  <= instr_dst;
                src_q  <= instr_src;
                im_q   <= instr_im;
                data_q <= instr_data;
            end
            case (state)
                ST_READ: begin
                    alu_in1 <= rd_a;
                    alu_in2 <= rd_b;
                    alu_im  <= im_q;
                    alu_op  <= cls.uses_alu ? op_q : OP_NOP;
                    lat_cnt <= LAT_INIT;
                end
                ST_EXEC: begin
                    if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
                end
                ST_WB: begin
                    done    <= 1'b1;
                    illegal <= cls.illegal;
                    alu_op  <= OP_NOP;
                    if (op_q == OP_SHOWR) begin
                        show_valid <= 1'b1;
                        show_data  <= rd_a;
                    end
                    if (cls.writes_flags) begin
                        flags[FLAG_CF] <= alu_cf;
                        flags[FLAG_ZF] <= alu_zf;
                        flags[FLAG_SF] <= alu_sf;
                        flags[FLAG_OF] <= alu_of;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    // Retired-instruction counter; illegal opcodes do not count, wraps naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_count <= '0;
        end else if ((state == ST_WB) && !cls.illegal) begin
            retired_count <= retired_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Single-issue controller that sequences the 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8x8 register file.
- Drives the ALU, waits a fixed latency, then writes the result back and updates the architectural flags {CF,ZF,SF,OF}.
- Sits between the instruction source and the ALU. Owns all register and flag state.

Parameters:
- ALU_LAT, 1, cycles from ALU inputs driven to alu_res/flags valid (range 1-15).
- NREGS, 8, register count; fixed, since addresses are 3 bits.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- instr_op  in  5  opcode
- instr_dst  in  3  destination register; also in1 source
- instr_src  in  3  in2 source register
- instr_im  in  3  shift/rotate amount
- instr_data  in  8  immediate byte, LDI only
- alu_in1 / alu_in2  out  8  ALU operands
- alu_im  out  3  ALU shift amount
- alu_op  out  5  ALU opcode
- alu_res  in  8  ALU result
- alu_cf / alu_zf / alu_sf / alu_of  in  1  ALU flags
- flags  out  4  architectural {CF,ZF,SF,OF}
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse, coincident with done, for an unsupported opcode
- show_valid  out  1  one-cycle pulse on SHOWR
- show_data  out  8  register value for SHOWR; held until the next SHOWR

Behaviour:
- Reset values: all registers 00, flags 0000, instr_ready 0, done/illegal/show_valid 0, show_data 00, alu_op 00000 (NOP), alu_in1/alu_in2/alu_im 0, state IDLE.
- Reset asserted mid-instruction aborts it. No write-back and no done pulse occur.
- Opcodes: NOP 00000, ADD 00001, AND 00010, SUB 00011, OR 00100, XOR 00101, MOV 00110, ADC 00111, NOT 01000, SAR 01001, SLR 01010, SAL 01011, SLL 01100, ROL 01101, ROR 01110, LDI 10000, SHOWR 11111.
- 10001-11110 are illegal.
- State machine:
  - IDLE: instr_ready=1. On valid&ready, latch op/dst/src/im/data and go to READ. instr_ready is registered and drops to 0 the cycle after acceptance.
  - READ: read reg[dst] and reg[src] asynchronously and register them onto alu_in1/alu_in2; drive alu_im and alu_op.
    - ALU ops go to EXEC.
    - LDI, SHOWR, NOP and illegal opcodes go straight to WB with alu_op held at NOP.
  - EXEC: hold ALU inputs stable for ALU_LAT cycles (down-counter), then go to WB.
  - WB: perform one write and/or flag update, pulse done, return to IDLE. instr_ready is 1 the next cycle.
- Timing, with acceptance at edge T:
  - ALU ops retire (done high) in cycle T+2+ALU_LAT.
  - LDI/SHOWR/NOP/illegal retire in cycle T+2.
  - Back-to-back ALU throughput is 1 per 3+ALU_LAT cycles.
- Write-back rules:
  - Registers: ADD through ROR write alu_res to dst; LDI writes instr_data to dst; NOP, SHOWR and illegal write nothing.
  - Flags: ADD, AND, SUB, OR, XOR, ADC, SAR, SLR, SAL, SLL, ROL and ROR load alu flags. MOV, NOT, LDI, SHOWR, NOP and illegal leave flags unchanged.
  - ADC is passed through unchanged. The ALU supplies the carry behaviour.
- dst==src is legal; both operands read the same value.
- instr_valid held while instr_ready=0 is ignored. Fields are sampled only at acceptance.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- When defined:
  - Adds output retired_count[15:0], reset to 0000.
  - Increments in WB for every non-illegal instruction; NOP counts.
  - Wraps from FFFF to 0000.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package alu_ctrl_pkg:
  - opcode constants
  - state encoding (IDLE/READ/EXEC/WB)
  - flag bit indices CF=3, ZF=2, SF=1, OF=0
  - function classifying opcodes as writes_reg / writes_flags / uses_alu / illegal
- Sub-module alu_regfile: 8x8 registers, two asynchronous read ports, one synchronous write port, asynchronous active-low reset to 00.

Test Plan:
- Reset release → instr_ready 0 in the first cycle, 1 from the next. Then LDI r1=7F, LDI r2=01, ADD dst=r1 src=r2 (ALU_LAT=1) → done 3 cycles after the ADD accept edge, r1=80, flags=0011.
- LDI r3=FF, LDI r4=01, ADD r3,r4 → r3=00, flags=1100. Then ADC r5,r6 (both 00) → r5=01 and flags come from the ALU.
- SHOWR dst=r1 after test 1 → show_valid pulses one cycle, show_data=80, flags and r1 unchanged, done 2 cycles after accept.
- op=10101 → illegal and done pulse together, registers and flags unchanged, alu_op stays 00000, instr_ready returns. With INSTR_COUNT_EN, the count does not increment.
- reset_n pulsed low during EXEC of ADD → no done, registers 00, flags 0000, instr_ready 0 until after release.
- instr_valid held high continuously with 4 queued ADDs → exactly one accept per 4 cycles (ALU_LAT=1), no lost or duplicated instructions. With INSTR_COUNT_EN preloaded near FFFF, the count wraps FFFF→0000.
